// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one full-subtractor step per clock.
// Start/busy/done handshake; results are registered and held until the next completion.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;
  localparam int CW = (WIDTH < 2) ? 1 : $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [0:0]       state_q,  state_d;
  logic [WIDTH-1:0] ra_q,     ra_d;
  logic [WIDTH-1:0] rb_q,     rb_d;
  logic [WIDTH-1:0] rd_q,     rd_d;
  logic             sa_q,     sa_d;
  logic             sb_q,     sb_d;
  logic             borrow_q, borrow_d;
  logic [CW-1:0]    count_q,  count_d;
  logic             done_q,   done_d;
  logic [WIDTH-1:0] diff_q,   diff_d;
  logic             bout_q,   bout_d;
  logic             ovf_q,    ovf_d;

  logic             d_bit;
  logic             borrow_nx;
  logic [WIDTH-1:0] rd_shift;

  assign d_bit     = ra_q[0] ^ rb_q[0] ^ borrow_q;
  assign borrow_nx = (~ra_q[0] & rb_q[0]) | (~(ra_q[0] ^ rb_q[0]) & borrow_q);

  // The result register fills from the MSB side so the last bit lands at [WIDTH-1].
  generate
    if (WIDTH == 1) begin : g_rd_one
      assign rd_shift = d_bit;
    end else begin : g_rd_many
      assign rd_shift = {d_bit, rd_q[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    state_d  = state_q;
    ra_d     = ra_q;
    rb_d     = rb_q;
    rd_d     = rd_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    borrow_d = borrow_q;
    count_d  = count_q;
    done_d   = 1'b0;
    diff_d   = diff_q;
    bout_d   = bout_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          ra_d     = a;
          rb_d     = b;
          sa_d     = a[WIDTH-1];
          sb_d     = b[WIDTH-1];
          borrow_d = 1'b0;
          count_d  = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        borrow_d = borrow_nx;
        ra_d     = ra_q >> 1;
        rb_d     = rb_q >> 1;
        rd_d     = rd_shift;
        count_d  = count_q + CW'(1);
        if (count_q == LAST) begin
          diff_d  = rd_shift;
          bout_d  = borrow_nx;
          ovf_d   = (sa_q != sb_q) && (rd_shift[WIDTH-1] != sa_q);
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      ra_q     <= '0;
      rb_q     <= '0;
      rd_q     <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      borrow_q <= 1'b0;
      count_q  <= '0;
      done_q   <= 1'b0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ra_q     <= ra_d;
      rb_q     <= rb_d;
      rd_q     <= rd_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      borrow_q <= borrow_d;
      count_q  <= count_d;
      done_q   <= done_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;
  assign ovf  = ovf_q;

endmodule
